ddr_rx: RTL
===========

Name: ddr_rx

Overview:
HDR-DDR deserializer, the receive-side counterpart of the controller's DDR serializer. It samples SDA on every SCL edge strobe (both edges, DDR) supplied by the SCL generator. Under control of the DDR/CCC FSM it recovers preambles, data bytes, parity, CRC token and CRC value, and flags protocol errors. Received bytes go to the register file and the CRC engine. Sits between the SDA handler and the DDR/CCC FSM.

Parameters:
DATA_W, 8, width of one deserialized byte (fixed by protocol; not to be overridden)
CRC_W, 5, width of the CRC value field

Ports:
i_sys_clk  input  1  system clock
i_sys_rst  input  1  asynchronous active-low reset
i_ddrccc_rx_en  input  1  block enable from DDR/CCC FSM
i_ddrccc_rx_mode  input  3  field to receive (encoding below)
i_sclgen_scl_pos_edge  input  1  one-cycle strobe, SCL rising edge
i_sclgen_scl_neg_edge  input  1  one-cycle strobe, SCL falling edge
i_sdahnd_rx_sda  input  1  synchronized SDA level
i_crc_value  input  5  CRC computed by CRC engine over received bytes
o_regf_wr_en  output  1  one-cycle pulse, byte valid on o_regf_rx_data
o_regf_rx_data  output  8  last received byte
o_ddrccc_preamble  output  2  last received preamble, first bit in [1]
o_ddrccc_mode_done  output  1  one-cycle pulse, current field complete
o_ddrccc_error  output  1  one-cycle pulse with mode_done on parity/token/CRC mismatch
o_crc_en  output  1  high while in byte-receiving mode
o_crc_data_valid  output  1  one-cycle pulse, byte valid on o_crc_parallel_data
o_crc_parallel_data  output  8  received byte to CRC engine
o_crc_last_byte  output  1  one-cycle pulse when the CRC token is accepted

Behaviour:
- Clock i_sys_clk. Reset i_sys_rst is asynchronous, active-low.
- Reset values: all outputs 0. Internal state also cleared: bit counter 0, byte index 0, D1 = D2 = 0, shift register 0.
- Mode encoding and field length N:
  - 0 preamble, N=2
  - 1 data byte, N=8
  - 2 parity, N=2
  - 3 CRC token, N=4
  - 4 CRC value, N=5
  - 5-7 idle: no sampling, no outputs.
- Sample strobe = pos_edge OR neg_edge. If both are high in one cycle, that counts as one sample.
- On each strobe with rx_en=1: shift SDA into the shift register MSB-first and increment the bit counter.
- Completion: on the clock edge where the N-th bit is sampled, register results and pulse mode_done. Latency: results and pulse are visible the cycle after the last strobe. The bit counter returns to 0.
  - Further strobes in the same mode start a new field, so back-to-back bytes need no idle cycle.
- Byte mode:
  - On completion, drive the byte on o_regf_rx_data and o_crc_parallel_data. Pulse o_regf_wr_en and o_crc_data_valid.
  - Store the byte in D1 if byte index = 0, else in D2. Toggle the byte index.
  - o_crc_en = 1 whenever rx_en=1 and mode=1.
- Parity mode:
  - Expected P1 = XOR of bits 7,5,3,1 of D1 and D2.
  - Expected P0 = XOR of bits 6,4,2,0 of D1 and D2, XOR 1.
  - Received {b1,b0} != {P1,P0} -> error pulse.
  - Byte index resets to 0 on completion.
- Token mode: received != 4'b1100 -> error pulse; otherwise pulse o_crc_last_byte.
- CRC value mode: received 5 bits != i_crc_value -> error pulse. i_crc_value is sampled at completion.
- Preamble mode: o_ddrccc_preamble is updated on completion and holds until the next preamble. Never raises an error.
- rx_en=0: bit counter, shift register and byte index clear within one cycle; partial fields are discarded. Registered data outputs hold their values; pulse outputs are 0.
- Mode change while enabled and mid-field: bit counter clears on the cycle the mode differs from the registered mode. The new field starts fresh.
- Reset mid-field: immediate clear; no done pulse.

Test Plan:
- Preamble: SDA 1,0 on two edges -> mode_done pulse; o_ddrccc_preamble=2'b10; error=0.
- Data word: bytes 0xA5 then 0x3C MSB-first over 16 edges, then parity 0,1 -> two wr_en/crc_data_valid pulses with 0xA5 and 0x3C; parity done with error=0. Same sequence with parity 1,1 -> error=1 with mode_done.
- Token: 1,1,0,0 -> done, o_crc_last_byte pulse, error=0. Token 1,1,0,1 -> error pulse, no last_byte.
- CRC: i_crc_value=5'h13, SDA 1,0,0,1,1 -> done, error=0. SDA 1,0,0,1,0 -> error=1.
- Abort: 4 bits of a byte, drop rx_en for 1 cycle, re-enable, send 0x5A -> single wr_en pulse with 0x5A and no spurious pulse.
- Simultaneous pos and neg strobe in one cycle counts as one bit; assert reset mid-byte -> all outputs 0 immediately.

Source files
------------

// File: rtl/ddr_rx.sv
// HDR-DDR receive deserializer: samples SDA on every SCL edge strobe and recovers
// preambles, data bytes, parity, CRC token and CRC value for the DDR/CCC FSM.
module ddr_rx #(
   parameter int DATA_W = 8,
   parameter int CRC_W  = 5
) (
   input  logic              i_sys_clk,
   input  logic              i_sys_rst,
   input  logic              i_ddrccc_rx_en,
   input  logic [2:0]        i_ddrccc_rx_mode,
   input  logic              i_sclgen_scl_pos_edge,
   input  logic              i_sclgen_scl_neg_edge,
   input  logic              i_sdahnd_rx_sda,
   input  logic [CRC_W-1:0]  i_crc_value,
   output logic              o_regf_wr_en,
   output logic [DATA_W-1:0] o_regf_rx_data,
   output logic [1:0]        o_ddrccc_preamble,
   output logic              o_ddrccc_mode_done,
   output logic              o_ddrccc_error,
   output logic              o_crc_en,
   output logic              o_crc_data_valid,
   output logic [DATA_W-1:0] o_crc_parallel_data,
   output logic              o_crc_last_byte
);

   localparam logic [2:0] MODE_PREAMBLE = 3'd0;
   localparam logic [2:0] MODE_BYTE     = 3'd1;
   localparam logic [2:0] MODE_PARITY   = 3'd2;
   localparam logic [2:0] MODE_TOKEN    = 3'd3;
   localparam logic [2:0] MODE_CRC      = 3'd4;
   localparam logic [3:0] CRC_TOKEN     = 4'b1100;

   logic [2:0]        mode_q;
   logic [2:0]        cnt_q, cnt_d, cnt_base;
   logic [DATA_W-1:0] shift_q, shift_d, shift_base, shift_nxt;
   logic              idx_q, idx_d;
   logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic [1:0]        preamble_q, preamble_d;
   logic              wr_en_q, wr_en_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              last_q, last_d;
   logic              crc_en_q, crc_en_d;
   logic [2:0]        last_bit;
   logic              mode_valid;
   logic              strobe;
   logic [1:0]        parity_exp;

   assign strobe = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;

   // Odd bits feed P1, even bits feed P0; P0 is inverted so an all-zero word still toggles SDA.
   assign parity_exp[1] = d1_q[7] ^ d1_q[5] ^ d1_q[3] ^ d1_q[1] ^
                          d2_q[7] ^ d2_q[5] ^ d2_q[3] ^ d2_q[1];
   assign parity_exp[0] = d1_q[6] ^ d1_q[4] ^ d1_q[2] ^ d1_q[0] ^
                          d2_q[6] ^ d2_q[4] ^ d2_q[2] ^ d2_q[0] ^ 1'b1;

   always_comb begin
      last_bit   = 3'd0;
      mode_valid = 1'b1;
      case (i_ddrccc_rx_mode)
         MODE_PREAMBLE: last_bit = 3'd1;
         MODE_BYTE:     last_bit = 3'd7;
         MODE_PARITY:   last_bit = 3'd1;
         MODE_TOKEN:    last_bit = 3'd3;
         MODE_CRC:      last_bit = 3'd4;
         default:       mode_valid = 1'b0;
      endcase
   end

   always_comb begin
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      idx_d      = idx_q;
      d1_d       = d1_q;
      d2_d       = d2_q;
      rx_data_d  = rx_data_q;
      preamble_d = preamble_q;
      wr_en_d    = 1'b0;
      done_d     = 1'b0;
      error_d    = 1'b0;
      last_d     = 1'b0;
      crc_en_d   = i_ddrccc_rx_en && (i_ddrccc_rx_mode == MODE_BYTE);
      cnt_base   = '0;
      shift_base = '0;
      shift_nxt  = '0;

      if (!i_ddrccc_rx_en) begin
         cnt_d   = '0;
         shift_d = '0;
         idx_d   = 1'b0;
      end else if (!mode_valid) begin
         cnt_d   = '0;
         shift_d = '0;
      end else begin
         // A mode change abandons any partial field; a strobe in that cycle is bit 0 of the new one.
         if (i_ddrccc_rx_mode == mode_q) begin
            cnt_base   = cnt_q;
            shift_base = shift_q;
         end
         cnt_d   = cnt_base;
         shift_d = shift_base;
         if (strobe) begin
            shift_nxt = {shift_base[DATA_W-2:0], i_sdahnd_rx_sda};
            if (cnt_base == last_bit) begin
               cnt_d   = '0;
               shift_d = '0;
               done_d  = 1'b1;
               case (i_ddrccc_rx_mode)
                  MODE_PREAMBLE: preamble_d = shift_nxt[1:0];
                  MODE_BYTE: begin
                     rx_data_d = shift_nxt;
                     wr_en_d   = 1'b1;
                     if (idx_q) d2_d = shift_nxt;
                     else       d1_d = shift_nxt;
                     idx_d = ~idx_q;
                  end
                  MODE_PARITY: begin
                     error_d = (shift_nxt[1:0] != parity_exp);
                     idx_d   = 1'b0;
                  end
                  MODE_TOKEN: begin
                     error_d = (shift_nxt[3:0] != CRC_TOKEN);
                     last_d  = (shift_nxt[3:0] == CRC_TOKEN);
                  end
                  default: error_d = (shift_nxt[CRC_W-1:0] != i_crc_value);
               endcase
            end else begin
               cnt_d   = cnt_base + 3'd1;
               shift_d = shift_nxt;
            end
         end
      end
   end

   always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
      if (!i_sys_rst) begin
         mode_q     <= '0;
         cnt_q      <= '0;
         shift_q    <= '0;
         idx_q      <= 1'b0;
         d1_q       <= '0;
         d2_q       <= '0;
         rx_data_q  <= '0;
         preamble_q <= '0;
         wr_en_q    <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         last_q     <= 1'b0;
         crc_en_q   <= 1'b0;
      end else begin
         mode_q     <= i_ddrccc_rx_mode;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         idx_q      <= idx_d;
         d1_q       <= d1_d;
         d2_q       <= d2_d;
         rx_data_q  <= rx_data_d;
         preamble_q <= preamble_d;
         wr_en_q    <= wr_en_d;
         done_q     <= done_d;
         error_q    <= error_d;
         last_q     <= last_d;
         crc_en_q   <= crc_en_d;
      end
   end

   assign o_regf_wr_en        = wr_en_q;
   assign o_regf_rx_data      = rx_data_q;
   assign o_ddrccc_preamble   = preamble_q;
   assign o_ddrccc_mode_done  = done_q;
   assign o_ddrccc_error      = error_q;
   assign o_crc_en            = crc_en_q;
   assign o_crc_data_valid    = wr_en_q;
   assign o_crc_parallel_data = rx_data_q;
   assign o_crc_last_byte     = last_q;

endmodule
